// File: rtl/uart_rx_frame_ctrl.sv
// rtl/uart_rx_frame_ctrl.sv - UART receive frame sequencer with baud-generator restart and valid/ready delivery
module uart_rx_frame_ctrl #(
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx,
   input  logic                 baud_clk,
   output logic                 restart_baud_clk,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
   } state_t;

   state_t               r_state, w_next_state;
   logic                 r_rx_meta, r_rx_s, r_baud_d, r_restart;
   logic [TW-1:0]        r_tick_cnt;
   logic [BW-1:0]        r_bit_idx;
   logic [DATA_BITS-1:0] r_shift, r_rx_data;
   logic                 r_perr, r_rx_valid, r_frame_err, r_parity_err, r_overrun;
   logic                 w_tick, w_half, w_full;
   logic                 w_restart, w_shift, w_par_sample, w_stop_sample;

   // Ticks are ignored while the generator is being restarted so the count starts from the start edge.
   assign w_tick = baud_clk && !r_baud_d && (r_state != S_IDLE) && !r_restart;
   assign w_half = w_tick && (r_tick_cnt == HALF_M1);
   assign w_full = w_tick && (r_tick_cnt == FULL_M1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
         r_baud_d  <= 1'b0;
         r_restart <= 1'b0;
         r_state   <= S_IDLE;
      end else begin
         r_rx_meta <= rx;
         r_rx_s    <= r_rx_meta;
         r_baud_d  <= baud_clk;
         r_restart <= w_restart;
         r_state   <= w_next_state;
      end
   end

   always_comb begin
      w_next_state  = r_state;
      w_restart     = 1'b0;
      w_shift       = 1'b0;
      w_par_sample  = 1'b0;
      w_stop_sample = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!r_rx_s) begin
               w_restart    = 1'b1;
               w_next_state = S_START;
            end
         end
         S_START: begin
            if (w_half) w_next_state = r_rx_s ? S_IDLE : S_DATA;
         end
         S_DATA: begin
            if (w_full) begin
               w_shift = 1'b1;
               if (r_bit_idx == LAST_BIT) w_next_state = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end
         end
         S_PARITY: begin
            if (w_full) begin
               w_par_sample = 1'b1;
               w_next_state = S_STOP;
            end
         end
         S_STOP: begin
            if (w_full) begin
               w_stop_sample = 1'b1;
               w_next_state  = r_rx_s ? S_IDLE : S_WAIT_HIGH;
            end
         end
         S_WAIT_HIGH: begin
            if (r_rx_s) w_next_state = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tick_cnt <= '0;
         r_bit_idx  <= '0;
         r_shift    <= '0;
         r_perr     <= 1'b0;
      end else begin
         if (w_next_state != r_state) r_tick_cnt <= '0;
         else if (w_tick)             r_tick_cnt <= r_tick_cnt + 1'b1;

         if (r_state != S_DATA) r_bit_idx <= '0;
         else if (w_shift)      r_bit_idx <= r_bit_idx + 1'b1;

         if (w_shift) r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};

         if (r_state == S_IDLE) r_perr <= 1'b0;
         else if (w_par_sample) r_perr <= ((^r_shift) ^ r_rx_s) != (PARITY_ODD != 0);
      end
   end

   // A completed frame is only dropped when the previous one is still pending and not taken this cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_data    <= '0;
         r_rx_valid   <= 1'b0;
         r_frame_err  <= 1'b0;
         r_parity_err <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_overrun <= 1'b0;
         if (w_stop_sample && (!r_rx_valid || rx_ready)) begin
            r_rx_data    <= r_shift;
            r_frame_err  <= !r_rx_s;
            r_parity_err <= r_perr;
            r_rx_valid   <= 1'b1;
         end else begin
            if (w_stop_sample) r_overrun  <= 1'b1;
            if (rx_ready)      r_rx_valid <= 1'b0;
         end
      end
   end

   assign restart_baud_clk = r_restart;
   assign rx_data          = r_rx_data;
   assign rx_valid         = r_rx_valid;
   assign frame_err        = r_frame_err;
   assign parity_err       = r_parity_err;
   assign overrun          = r_overrun;
   assign busy             = (r_state != S_IDLE);

endmodule
